// File: rtl/corelet_ctrl.sv
// corelet_ctrl: instruction sequencer for the weight-stationary corelet.
//
// For each kernel position k it loads col weight words from xmem through L0
// into the MAC array, streams len_nij activation vectors, then drains the
// OFIFO into pmem. After all kernel positions it runs an accumulate/ReLU pass
// that sums the kij_num partial sums per output and writes them at out_base.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   start        in   one-cycle request, honoured only when idle
//   ofifo_valid  in   OFIFO holds at least one complete row
//   inst[33:0]   out  instruction bus (acc, pmem ctl/addr, xmem ctl/addr, strobes)
//   busy         out  high whenever not idle
//   done         out  one-cycle pulse at the end of the schedule
module corelet_ctrl #(
    parameter int unsigned col      = 8,
    parameter int unsigned row      = 8,
    parameter int unsigned kij_num  = 9,
    parameter int unsigned len_nij  = 36,
    parameter int unsigned w_base   = 0,
    parameter int unsigned x_base   = 128,
    parameter int unsigned out_base = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done
);

    localparam logic [33:0] IdleWord = 34'h1800C0000;

    localparam logic [10:0] ColW   = 11'(col);
    localparam logic [10:0] FlushW = 11'(row + col);
    localparam logic [10:0] KijW   = 11'(kij_num);
    localparam logic [10:0] LenW   = 11'(len_nij);
    localparam logic [10:0] WBaseW = 11'(w_base);
    localparam logic [10:0] XBaseW = 11'(x_base);
    localparam logic [10:0] OBaseW = 11'(out_base);

    typedef enum logic [3:0] {
        StIdle, StWl0, StWgap, StWarr, StWflush,
        StXl0, StXgap, StExec, StDrain, StAcc, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;     // cycle index inside the current state/group
    logic [10:0] k_q, k_d;         // kernel position
    logic [10:0] n_q, n_d;         // output index during accumulation

    // Strobes for consumers of SRAM read data, one cycle behind the read.
    logic        l0_wr_q, l0_wr_d;
    logic        acc_q, acc_d;
    logic        pwr_q, pwr_d;
    logic [10:0] pwr_addr_q, pwr_addr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            k_q        <= '0;
            n_q        <= '0;
            l0_wr_q    <= 1'b0;
            acc_q      <= 1'b0;
            pwr_q      <= 1'b0;
            pwr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            n_q        <= n_d;
            l0_wr_q    <= l0_wr_d;
            acc_q      <= acc_d;
            pwr_q      <= pwr_d;
            pwr_addr_q <= pwr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        n_d        = n_q;
        l0_wr_d    = 1'b0;
        acc_d      = 1'b0;
        pwr_d      = 1'b0;
        pwr_addr_d = pwr_addr_q;
        inst       = IdleWord;
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);

        // Delayed strobes complete regardless of which state follows.
        if (l0_wr_q) inst[2] = 1'b1;
        if (acc_q)   inst[33] = 1'b1;
        if (pwr_q) begin
            inst[32]    = 1'b0;
            inst[31]    = 1'b0;
            inst[30:20] = pwr_addr_q;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWl0;
                    cnt_d   = '0;
                    k_d     = '0;
                    n_d     = '0;
                end
            end
            StWl0: begin
                inst[19]   = 1'b0;
                inst[17:7] = WBaseW + k_q * ColW + cnt_q;
                l0_wr_d    = 1'b1;
                if (cnt_q == ColW - 11'd1) begin
                    state_d = StWgap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StWgap: state_d = StWarr;
            StWarr: begin
                inst[3] = 1'b1;
                inst[0] = 1'b1;
                if (cnt_q == ColW - 11'd1) begin
                    state_d = StWflush;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StWflush: begin
                if (cnt_q == FlushW - 11'd1) begin
                    state_d = StXl0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StXl0: begin
                inst[19]   = 1'b0;
                inst[17:7] = XBaseW + cnt_q;
                l0_wr_d    = 1'b1;
                if (cnt_q == LenW - 11'd1) begin
                    state_d = StXgap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StXgap: state_d = StExec;
            StExec: begin
                inst[3] = 1'b1;
                inst[1] = 1'b1;
                if (cnt_q == LenW - 11'd1) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StDrain: begin
                if (cnt_q < LenW) begin
                    // Only the first read waits for ofifo_valid; the burst is never re-checked.
                    if (cnt_q != 11'd0 || ofifo_valid) begin
                        inst[6]    = 1'b1;
                        pwr_d      = 1'b1;
                        pwr_addr_d = k_q * LenW + cnt_q;
                        cnt_d      = cnt_q + 11'd1;
                    end
                end else begin
                    // Tail cycle carries the last pmem write.
                    cnt_d = '0;
                    if (k_q == KijW - 11'd1) begin
                        state_d = StAcc;
                        k_d     = '0;
                        n_d     = '0;
                    end else begin
                        state_d = StWl0;
                        k_d     = k_q + 11'd1;
                    end
                end
            end
            StAcc: begin
                if (cnt_q < KijW) begin
                    inst[32]    = 1'b0;
                    inst[30:20] = cnt_q * LenW + n_q;
                    acc_d       = 1'b1;
                end
                if (cnt_q == KijW + 11'd1) begin
                    inst[5]     = 1'b1;
                    inst[32]    = 1'b0;
                    inst[31]    = 1'b0;
                    inst[30:20] = OBaseW + n_q;
                    cnt_d       = '0;
                    if (n_q == LenW - 11'd1) begin
                        state_d = StDone;
                        n_d     = '0;
                    end else begin
                        n_d = n_q + 11'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Testbench for corelet_ctrl. The expected trace is painted onto a per-cycle
// timeline from the schedule description (reads, delayed consumer strobes,
// writes), then compared against the DUT every cycle.
module tb_corelet_ctrl;

    localparam int unsigned Col = 8, Row = 8, Kij = 2, Len = 4;
    localparam int unsigned WBase = 0, XBase = 128, OutBase = 1024;
    localparam logic [33:0] Idle = 34'h1800C0000;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_valid;
    logic [33:0] inst;
    logic        busy, done;

    corelet_ctrl #(
        .col(Col), .row(Row), .kij_num(Kij), .len_nij(Len),
        .w_base(WBase), .x_base(XBase), .out_base(OutBase)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = -1;
    logic        chk_en = 1'b0;
    logic [33:0] exp_inst = Idle;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;

    logic [33:0] mw [0:511];
    bit          mo [0:511];
    int          total;

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("inst", inst, exp_inst);
            check("busy", 34'(busy), 34'(exp_busy));
            check("done", 34'(done), 34'(exp_done));
        end
    end

    task automatic xread(input int c, input int a);
        mw[c][19]   = 1'b0;
        mw[c][17:7] = 11'(a);
    endtask

    task automatic pread(input int c, input int a);
        mw[c][32]    = 1'b0;
        mw[c][30:20] = 11'(a);
    endtask

    task automatic pwrite(input int c, input int a);
        mw[c][32]    = 1'b0;
        mw[c][31]    = 1'b0;
        mw[c][30:20] = 11'(a);
    endtask

    // Index 0 is the cycle after start is sampled. st0/st1: ofifo_valid-low
    // cycles at the head of DRAIN for k=0/k=1; drop lowers it mid-burst.
    task automatic build_model(input int st0, input int st1, input bit drop);
        int c;
        for (int i = 0; i < 512; i++) begin
            mw[i] = Idle;
            mo[i] = 1'b1;
        end
        c = 0;
        for (int k = 0; k < Kij; k++) begin
            for (int i = 0; i < Col; i++) begin
                xread(c, WBase + k * Col + i);
                mw[c+1][2] = 1'b1;
                c++;
            end
            c++;
            for (int i = 0; i < Col; i++) begin
                mw[c][3] = 1'b1;
                mw[c][0] = 1'b1;
                c++;
            end
            c += Row + Col;
            for (int n = 0; n < Len; n++) begin
                xread(c, XBase + n);
                mw[c+1][2] = 1'b1;
                c++;
            end
            c++;
            for (int n = 0; n < Len; n++) begin
                mw[c][3] = 1'b1;
                mw[c][1] = 1'b1;
                c++;
            end
            for (int s = 0; s < ((k == 0) ? st0 : st1); s++) begin
                mo[c] = 1'b0;
                c++;
            end
            for (int n = 0; n < Len; n++) begin
                mw[c][6] = 1'b1;
                if (drop && n > 0 && n < 3) mo[c] = 1'b0;
                pwrite(c + 1, k * Len + n);
                c++;
            end
            c++;
        end
        for (int n = 0; n < Len; n++) begin
            for (int j = 0; j < Kij; j++) begin
                pread(c, j * Len + n);
                mw[c+1][33] = 1'b1;
                c++;
            end
            c++;
            pwrite(c, OutBase + n);
            mw[c][5] = 1'b1;
            c++;
        end
        c++;
        total = c;
    endtask

    task automatic set_idle_exp();
        exp_inst = Idle;
        exp_busy = 1'b0;
        exp_done = 1'b0;
    endtask

    // abort_at >= 0: assert reset (with start) at that index. perturb: pulse
    // start in XL0 and in DONE, both of which must be ignored.
    task automatic run_sched(input int abort_at, input bit perturb);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b1;
        ofifo_valid = 1'b1;
        cyc = -1;
        set_idle_exp();
        for (int i = 0; i < total; i++) begin
            @(posedge clk); #1;
            cyc = i;
            start = perturb && (i == 33 || i == total - 1);
            ofifo_valid = mo[i];
            exp_inst = mw[i];
            exp_busy = 1'b1;
            exp_done = (i == total - 1);
            if (i == abort_at) begin
                reset = 1'b1;
                start = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        cyc = -2;
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b1;
        set_idle_exp();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int formula;
        reset = 1'b1;
        start = 1'b1;
        ofifo_valid = 1'b0;
        set_idle_exp();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Pin the model against hand-computed words.
        build_model(0, 0, 1'b0);
        formula = Kij * (Col + 1 + Col + Row + Col + Len + 1 + Len + Len + 1)
                + Len * (Kij + 2) + 1;
        check("sched_len", 34'(total), 34'(formula));
        check("m_first_rd", mw[0], 34'h180040000);
        check("m_rd1_l0wr", mw[1], 34'h180040084);
        check("m_trail_l0wr", mw[8], 34'h1800C0004);
        check("m_load", mw[9], 34'h1800C0009);
        check("m_flush", mw[17], Idle);
        check("m_relu_wr", mw[total-2], 34'h0403C0020);
        check("m_done_word", mw[total-1], Idle);

        run_sched(-1, 1'b0);

        build_model(20, 3, 1'b1);
        run_sched(-1, 1'b0);

        build_model(0, 0, 1'b0);
        run_sched(39, 1'b0);
        run_sched(-1, 1'b0);
        run_sched(-1, 1'b1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
